alu_rs: RTL and testbench

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs.sv | 183 ++++++++++++++++++
 tb/tb_alu_rs.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU ops until both operands are
// available, snoops the CDB for wakeup, and issues the oldest-index ready entry.
module alu_rs #(
  parameter int unsigned RS_SIZE = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             disp_valid,
  input  logic [4:0]       disp_op,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic             disp_rj,
  input  logic             disp_rk,
  input  logic [31:0]      disp_addr,
  input  logic             disp_len,
  input  logic [TAG_W-1:0] disp_tag,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             flush,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [31:0]      alu_addr,
  output logic [4:0]       alu_op,
  output logic             alu_len,
  input  logic [31:0]      alu_result,
  input  logic             alu_jalr_done,
  input  logic [31:0]      alu_jalr_addr,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_value,
  output logic             out_jalr_done,
  output logic [31:0]      out_jalr_addr
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]            busy_q, busy_d, rj_q, rj_d, rk_q, rk_d, len_q, len_d;
  logic [RS_SIZE-1:0][4:0]       op_q, op_d;
  logic [RS_SIZE-1:0][31:0]      vj_q, vj_d, vk_q, vk_d, addr_q, addr_d;
  logic [RS_SIZE-1:0][TAG_W-1:0] qj_q, qj_d, qk_q, qk_d, tag_q, tag_d;

  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [31:0]      out_value_q, out_value_d;
  logic             out_jalr_done_q, out_jalr_done_d;
  logic [31:0]      out_jalr_addr_q, out_jalr_addr_d;

  logic [RS_SIZE-1:0] ready;
  logic               free_found, iss_found;
  logic [IDX_W-1:0]   free_idx, iss_idx;

  assign full          = &busy_q;
  assign ready         = busy_q & ~rj_q & ~rk_q;
  assign out_valid     = out_valid_q;
  assign out_tag       = out_tag_q;
  assign out_value     = out_value_q;
  assign out_jalr_done = out_jalr_done_q;
  assign out_jalr_addr = out_jalr_addr_q;

  // Priority pick of the lowest free slot and the lowest ready slot.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    iss_found  = 1'b0;
    iss_idx    = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready[i] && !iss_found) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_addr = '0;
    alu_op   = '0;
    alu_len  = 1'b0;
    if (iss_found) begin
      alu_op1  = vj_q[iss_idx];
      alu_op2  = vk_q[iss_idx];
      alu_addr = addr_q[iss_idx];
      alu_op   = op_q[iss_idx];
      alu_len  = len_q[iss_idx];
    end
  end

  always_comb begin
    busy_d = busy_q;  rj_d = rj_q;  rk_d = rk_q;  len_d = len_q;
    op_d   = op_q;    vj_d = vj_q;  vk_d = vk_q;  addr_d = addr_q;
    qj_d   = qj_q;    qk_d = qk_q;  tag_d = tag_q;
    out_valid_d     = out_valid_q;
    out_tag_d       = out_tag_q;
    out_value_d     = out_value_q;
    out_jalr_done_d = out_jalr_done_q;
    out_jalr_addr_d = out_jalr_addr_q;
    if (rdy_in) begin
      if (flush) begin
        busy_d      = '0;
        out_valid_d = 1'b0;
      end else begin
        if (cdb_valid) begin
          for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && rj_q[i] && qj_q[i] == cdb_tag) begin
              vj_d[i] = cdb_value;
              rj_d[i] = 1'b0;
            end
            if (busy_q[i] && rk_q[i] && qk_q[i] == cdb_tag) begin
              vk_d[i] = cdb_value;
              rk_d[i] = 1'b0;
            end
          end
        end
        out_valid_d = iss_found;
        if (iss_found) begin
          busy_d[iss_idx] = 1'b0;
          out_tag_d       = tag_q[iss_idx];
          out_value_d     = alu_result;
          out_jalr_done_d = alu_jalr_done;
          out_jalr_addr_d = alu_jalr_addr;
        end
        // free_found is the pre-edge view, so a slot issued this edge is not reused.
        if (disp_valid && free_found) begin
          busy_d[free_idx] = 1'b1;
          op_d[free_idx]   = disp_op;
          qj_d[free_idx]   = disp_qj;
          qk_d[free_idx]   = disp_qk;
          addr_d[free_idx] = disp_addr;
          len_d[free_idx]  = disp_len;
          tag_d[free_idx]  = disp_tag;
          if (disp_rj && cdb_valid && cdb_tag == disp_qj) begin
            vj_d[free_idx] = cdb_value;
            rj_d[free_idx] = 1'b0;
          end else begin
            vj_d[free_idx] = disp_vj;
            rj_d[free_idx] = disp_rj;
          end
          if (disp_rk && cdb_valid && cdb_tag == disp_qk) begin
            vk_d[free_idx] = cdb_value;
            rk_d[free_idx] = 1'b0;
          end else begin
            vk_d[free_idx] = disp_vk;
            rk_d[free_idx] = disp_rk;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;  rj_q <= '0;  rk_q <= '0;  len_q <= '0;
      op_q   <= '0;  vj_q <= '0;  vk_q <= '0;  addr_q <= '0;
      qj_q   <= '0;  qk_q <= '0;  tag_q <= '0;
      out_valid_q     <= 1'b0;
      out_tag_q       <= '0;
      out_value_q     <= '0;
      out_jalr_done_q <= 1'b0;
      out_jalr_addr_q <= '0;
    end else begin
      busy_q <= busy_d;  rj_q <= rj_d;  rk_q <= rk_d;  len_q <= len_d;
      op_q   <= op_d;    vj_q <= vj_d;  vk_q <= vk_d;  addr_q <= addr_d;
      qj_q   <= qj_d;    qk_q <= qk_d;  tag_q <= tag_d;
      out_valid_q     <= out_valid_d;
      out_tag_q       <= out_tag_d;
      out_value_q     <= out_value_d;
      out_jalr_done_q <= out_jalr_done_d;
      out_jalr_addr_q <= out_jalr_addr_d;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: a vector table of ready ops through a small
// reference ALU, plus sequences for wakeup, bypass, full/flush, stall, reset.
module tb_alu_rs;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_JALR = 5'd6;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, disp_valid, disp_rj, disp_rk, disp_len;
  logic [4:0]  disp_op;
  logic [31:0] disp_vj, disp_vk, disp_addr;
  logic [3:0]  disp_qj, disp_qk, disp_tag;
  logic        full, cdb_valid, flush;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [31:0] alu_op1, alu_op2, alu_addr;
  logic [4:0]  alu_op;
  logic        alu_len;
  logic [31:0] alu_result, alu_jalr_addr;
  logic        alu_jalr_done;
  logic        out_valid, out_jalr_done;
  logic [3:0]  out_tag;
  logic [31:0] out_value, out_jalr_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  alu_rs #(.RS_SIZE(4), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_rj(disp_rj), .disp_rk(disp_rk),
    .disp_addr(disp_addr), .disp_len(disp_len), .disp_tag(disp_tag), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .flush(flush),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_addr(alu_addr), .alu_op(alu_op),
    .alu_len(alu_len), .alu_result(alu_result), .alu_jalr_done(alu_jalr_done),
    .alu_jalr_addr(alu_jalr_addr), .out_valid(out_valid), .out_tag(out_tag),
    .out_value(out_value), .out_jalr_done(out_jalr_done), .out_jalr_addr(out_jalr_addr)
  );

  // Reference ALU attached to the alu_* port group.
  always_comb begin
    alu_result    = '0;
    alu_jalr_done = 1'b0;
    alu_jalr_addr = '0;
    case (alu_op)
      OP_ADD:  alu_result = alu_op1 + alu_op2;
      OP_SUB:  alu_result = alu_op1 - alu_op2;
      OP_AND:  alu_result = alu_op1 & alu_op2;
      OP_OR:   alu_result = alu_op1 | alu_op2;
      OP_XOR:  alu_result = alu_op1 ^ alu_op2;
      OP_SLL:  alu_result = alu_op1 << alu_op2[4:0];
      OP_JALR: begin
        alu_result    = alu_addr + (alu_len ? 32'd4 : 32'd2);
        alu_jalr_done = 1'b1;
        alu_jalr_addr = (alu_op1 + alu_op2) & ~32'd1;
      end
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] vj, vk, addr;
    logic        len;
    logic [3:0]  tag;
    logic [31:0] exp_val;
    logic        exp_jd;
    logic [31:0] exp_ja;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0; disp_op = '0; disp_vj = '0; disp_vk = '0;
    disp_qj = '0; disp_qk = '0; disp_rj = 1'b0; disp_rk = 1'b0;
    disp_addr = '0; disp_len = 1'b0; disp_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; flush = 1'b0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic rj, input logic [3:0] qj, input logic rk, input logic [3:0] qk,
                      input logic [31:0] addr, input logic len, input logic [3:0] tag);
    disp_valid = 1'b1; disp_op = op; disp_vj = vj; disp_vk = vk;
    disp_rj = rj; disp_qj = qj; disp_rk = rk; disp_qk = qk;
    disp_addr = addr; disp_len = len; disp_tag = tag;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] value);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = value;
  endtask

  initial begin
    vecs[0] = '{OP_ADD,  32'd5,          32'd7,          32'h0,   1'b1, 4'd3,  32'd12,         1'b0, 32'h0};
    vecs[1] = '{OP_SUB,  32'd3,          32'd5,          32'h0,   1'b1, 4'd1,  32'hFFFF_FFFE,  1'b0, 32'h0};
    vecs[2] = '{OP_AND,  32'hF0F0_00FF,  32'h0FF0_0F0F,  32'h0,   1'b1, 4'd7,  32'h00F0_000F,  1'b0, 32'h0};
    vecs[3] = '{OP_OR,   32'h0000_1200,  32'h0000_0034,  32'h0,   1'b1, 4'd15, 32'h0000_1234,  1'b0, 32'h0};
    vecs[4] = '{OP_XOR,  32'hFFFF_0000,  32'h0F0F_0F0F,  32'h0,   1'b1, 4'd0,  32'hF0F0_0F0F,  1'b0, 32'h0};
    vecs[5] = '{OP_SLL,  32'd1,          32'd31,         32'h0,   1'b1, 4'd9,  32'h8000_0000,  1'b0, 32'h0};
    vecs[6] = '{OP_JALR, 32'h1000,       32'h5,          32'h200, 1'b1, 4'd2,  32'h204,        1'b1, 32'h1004};
    vecs[7] = '{OP_JALR, 32'h40,         32'h0,          32'h300, 1'b0, 4'd4,  32'h302,        1'b1, 32'h40};

    idle();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    #2;
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_alu_op1", alu_op1, 0);
    step(); step();
    rst_in = 1'b0;
    step();

    // Ready ops: issue one edge after dispatch, one-cycle pulse.
    for (int i = 0; i < 8; i++) begin
      disp(vecs[i].op, vecs[i].vj, vecs[i].vk, 1'b0, 4'd0, 1'b0, 4'd0,
           vecs[i].addr, vecs[i].len, vecs[i].tag);
      step();
      idle();
      chk($sformatf("vec%0d_early", i), out_valid, 0);
      chk($sformatf("vec%0d_alu_op1", i), alu_op1, vecs[i].vj);
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_tag", i), out_tag, vecs[i].tag);
      chk($sformatf("vec%0d_value", i), out_value, vecs[i].exp_val);
      chk($sformatf("vec%0d_jdone", i), out_jalr_done, vecs[i].exp_jd);
      chk($sformatf("vec%0d_jaddr", i), out_jalr_addr, vecs[i].exp_ja);
      step();
      chk($sformatf("vec%0d_pulse_end", i), out_valid, 0);
    end

    // Wakeup through the CDB.
    disp(OP_SUB, 32'd99, 32'd4, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 1'b1, 4'd5);
    step();
    idle();
    chk("wk_wait0", out_valid, 0);
    step();
    chk("wk_wait1", out_valid, 0);
    cdb(4'd2, 32'd10);
    step();
    idle();
    chk("wk_no_same_edge_issue", out_valid, 0);
    chk("wk_alu_op1", alu_op1, 32'd10);
    step();
    chk("wk_valid", out_valid, 1);
    chk("wk_tag", out_tag, 5);
    chk("wk_value", out_value, 6);
    step();
    chk("wk_pulse_end", out_valid, 0);

    // Same-cycle bypass at dispatch.
    disp(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0, 32'h0, 1'b1, 4'd11);
    cdb(4'd6, 32'd9);
    step();
    idle();
    chk("byp_alu_op1", alu_op1, 32'd9);
    step();
    chk("byp_valid", out_valid, 1);
    chk("byp_tag", out_tag, 11);
    chk("byp_value", out_value, 10);
    step();

    // Fill, drop, flush, stale broadcasts.
    for (int i = 0; i < 4; i++) begin
      disp(OP_ADD, 32'd0, 32'd1, 1'b1, 4'(8 + i), 1'b0, 4'd0, 32'h0, 1'b1, 4'(1 + i));
      step();
      chk($sformatf("fill%0d_full", i), full, (i == 3) ? 1 : 0);
    end
    disp(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd12);
    step();
    idle();
    chk("drop_full", full, 1);
    chk("drop_valid0", out_valid, 0);
    step();
    chk("drop_valid1", out_valid, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_full", full, 0);
    chk("flush_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      cdb(4'(8 + i), 32'd0);
      step();
      chk($sformatf("stale%0d_valid", i), out_valid, 0);
    end
    idle();
    step();
    chk("stale_tail_valid", out_valid, 0);

    // Stall holds everything, including a pending pulse.
    disp(OP_ADD, 32'd20, 32'd22, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd6);
    step();
    idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_valid", i), out_valid, 0);
    end
    rdy_in = 1'b1;
    step();
    chk("stall_rel_valid", out_valid, 1);
    chk("stall_rel_tag", out_tag, 6);
    chk("stall_rel_value", out_value, 42);
    rdy_in = 1'b0;
    step();
    chk("stall_hold_valid", out_valid, 1);
    chk("stall_hold_value", out_value, 42);
    step();
    chk("stall_hold2_valid", out_valid, 1);
    rdy_in = 1'b1;
    step();
    chk("stall_after_valid", out_valid, 0);

    // Mid-run reset discards pending entries and an in-flight pulse.
    for (int i = 0; i < 3; i++) begin
      disp(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd13, 1'b0, 4'd0, 32'h0, 1'b1, 4'(1 + i));
      step();
    end
    disp(OP_ADD, 32'd2, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd8);
    step();
    idle();
    chk("mr_full", full, 1);
    step();
    chk("mr_pre_valid", out_valid, 1);
    chk("mr_pre_value", out_value, 5);
    rst_in = 1'b1;
    #1;
    chk("mr_rst_full", full, 0);
    chk("mr_rst_valid", out_valid, 0);
    chk("mr_rst_value", out_value, 0);
    step(); step();
    rst_in = 1'b0;
    disp(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd14, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7);
    step();
    disp(OP_ADD, 32'd0, 32'd2, 1'b1, 4'd15, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9);
    step();
    disp(OP_ADD, 32'd0, 32'd3, 1'b1, 4'd15, 1'b0, 4'd0, 32'h0, 1'b1, 4'd10);
    step();
    idle();
    chk("pr_full", full, 0);
    cdb(4'd13, 32'd77);
    step();
    idle();
    step();
    chk("pr_stale_valid", out_valid, 0);
    cdb(4'd14, 32'd100);
    step();
    idle();
    chk("pr_wake_valid", out_valid, 0);
    step();
    chk("pr_a_valid", out_valid, 1);
    chk("pr_a_tag", out_tag, 7);
    chk("pr_a_value", out_value, 101);
    cdb(4'd15, 32'd5);
    step();
    idle();
    chk("pr_a_end", out_valid, 0);
    step();
    chk("pr_b_valid", out_valid, 1);
    chk("pr_b_tag", out_tag, 9);
    chk("pr_b_value", out_value, 7);
    step();
    chk("pr_c_valid", out_valid, 1);
    chk("pr_c_tag", out_tag, 10);
    chk("pr_c_value", out_value, 8);
    step();
    chk("pr_end_valid", out_valid, 0);
    chk("pr_end_full", full, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
